// File: rtl/bomberman_pkg.sv
// Shared Bomberman definitions: button bus indices, per-button FSM states and
// default timing for the button conditioner.
package bomberman_pkg;

  localparam int BTN_L    = 0;
  localparam int BTN_U    = 1;
  localparam int BTN_D    = 2;
  localparam int BTN_R    = 3;
  localparam int BTN_C    = 4;
  localparam int NUM_BTNS = 5;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY    = 25_000_000;
  localparam int DEF_REPEAT_PERIOD   = 10_000_000;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_QUAL = 2'd1,
    HELD       = 2'd2,
    REL_QUAL   = 2'd3
  } btn_state_e;

endpackage

// File: rtl/btn_debounce_one.sv
// One button channel: 2-flop synchronizer, debounce FSM, and press and
// auto-repeat pulse generation. All outputs are registered.
module btn_debounce_one
  import bomberman_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic db,
  output logic scen,
  output logic mcen
);

  localparam int R_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int QW    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RW    = $clog2(R_MAX) + 1;
  localparam bit D_ONE = (DEBOUNCE_CYCLES == 1);
  // The first qualifying sample is taken in IDLE, so qualification ends when
  // qcnt has counted DEBOUNCE_CYCLES-2 further samples.
  localparam int Q_PRE_I = D_ONE ? 0 : DEBOUNCE_CYCLES - 2;
  localparam logic [QW-1:0] Q_PRE      = QW'(Q_PRE_I);
  localparam logic [RW-1:0] R_DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_PER_LAST = RW'(REPEAT_PERIOD - 1);

  function automatic logic [QW-1:0] qcnt_inc(input logic [QW-1:0] v);
    return (&v) ? v : v + QW'(1);
  endfunction

  function automatic logic [RW-1:0] rcnt_inc(input logic [RW-1:0] v);
    return (&v) ? v : v + RW'(1);
  endfunction

  btn_state_e      state_q, state_d;
  logic            sync1_q, sync1_d, sync2_q, sync2_d;
  logic [QW-1:0]   qcnt_q, qcnt_d;
  logic [RW-1:0]   rcnt_q, rcnt_d;
  logic            first_q, first_d;
  logic            db_q, db_d, scen_q, scen_d, mcen_q, mcen_d;
  logic [RW-1:0]   rcnt_tgt;

  assign rcnt_tgt = first_q ? R_DLY_LAST : R_PER_LAST;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    state_d = state_q;
    qcnt_d  = qcnt_q;
    rcnt_d  = rcnt_q;
    first_d = first_q;
    db_d    = db_q;
    scen_d  = 1'b0;
    mcen_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync2_q) begin
          if (D_ONE) begin
            state_d = HELD;
            db_d    = 1'b1;
            scen_d  = 1'b1;
            mcen_d  = 1'b1;
            rcnt_d  = '0;
            first_d = 1'b1;
          end else begin
            state_d = PRESS_QUAL;
            qcnt_d  = '0;
          end
        end
      end
      PRESS_QUAL: begin
        if (!sync2_q) begin
          state_d = IDLE;
        end else if (qcnt_q == Q_PRE) begin
          state_d = HELD;
          db_d    = 1'b1;
          scen_d  = 1'b1;
          mcen_d  = 1'b1;
          rcnt_d  = '0;
          first_d = 1'b1;
        end else begin
          qcnt_d = qcnt_inc(qcnt_q);
        end
      end
      HELD: begin
        if (!sync2_q) begin
          if (D_ONE) begin
            state_d = IDLE;
            db_d    = 1'b0;
          end else begin
            state_d = REL_QUAL;
            qcnt_d  = '0;
          end
        end else if (rcnt_q == rcnt_tgt) begin
          mcen_d  = 1'b1;
          rcnt_d  = '0;
          first_d = 1'b0;
        end else begin
          rcnt_d = rcnt_inc(rcnt_q);
        end
      end
      REL_QUAL: begin
        // Returning to HELD keeps rcnt so the repeat cadence is not restarted.
        if (sync2_q) begin
          state_d = HELD;
        end else if (qcnt_q == Q_PRE) begin
          state_d = IDLE;
          db_d    = 1'b0;
        end else begin
          qcnt_d = qcnt_inc(qcnt_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      qcnt_q  <= '0;
      rcnt_q  <= '0;
      first_q <= 1'b0;
      db_q    <= 1'b0;
      scen_q  <= 1'b0;
      mcen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      qcnt_q  <= qcnt_d;
      rcnt_q  <= rcnt_d;
      first_q <= first_d;
      db_q    <= db_d;
      scen_q  <= scen_d;
      mcen_q  <= mcen_d;
    end
  end

  assign db   = db_q;
  assign scen = scen_q;
  assign mcen = mcen_q;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the five Nexys4 push-buttons into debounced levels, press pulses
// and auto-repeat pulses, one independent channel per button.
module btn_conditioner
  import bomberman_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                ClkPort,
  input  logic                Reset_n,
  input  logic                BtnL,
  input  logic                BtnU,
  input  logic                BtnD,
  input  logic                BtnR,
  input  logic                BtnC,
  output logic [NUM_BTNS-1:0] Btn_db,
  output logic [NUM_BTNS-1:0] Btn_SCEN,
  output logic [NUM_BTNS-1:0] Btn_MCEN
);

  logic [NUM_BTNS-1:0] btn_raw;

  assign btn_raw[BTN_L] = BtnL;
  assign btn_raw[BTN_U] = BtnU;
  assign btn_raw[BTN_D] = BtnD;
  assign btn_raw[BTN_R] = BtnR;
  assign btn_raw[BTN_C] = BtnC;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_debounce_one #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk    (ClkPort),
      .rst_n  (Reset_n),
      .btn_raw(btn_raw[i]),
      .db     (Btn_db[i]),
      .scen   (Btn_SCEN[i]),
      .mcen   (Btn_MCEN[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: a run-length reference model predicts
// every cycle's outputs; a negedge monitor compares them against the DUT.
module tb_btn_conditioner;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic       clk = 1'b0;
  logic       Reset_n;
  logic [4:0] raw;
  logic [4:0] Btn_db, Btn_SCEN, Btn_MCEN;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .ClkPort (clk),
    .Reset_n (Reset_n),
    .BtnL    (raw[0]),
    .BtnU    (raw[1]),
    .BtnD    (raw[2]),
    .BtnR    (raw[3]),
    .BtnC    (raw[4]),
    .Btn_db  (Btn_db),
    .Btn_SCEN(Btn_SCEN),
    .Btn_MCEN(Btn_MCEN)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int edge_cnt = 0;
  logic [14:0] exp_q[$];

  // Reference model state: synchronizer pipe, accepted level, length of the
  // current run of samples disagreeing with it, and HELD-cycle repeat count.
  logic [4:0] m_s1, m_s2, m_db, m_first;
  int m_run[5];
  int m_rc[5];

  // Observations gathered by the monitor for the directed latency checks.
  int scen_edge[5];
  int fall_edge[5];
  int scen_cnt[5];
  int mcen_cnt[5];
  logic [4:0] prev_db = '0;

  task automatic model_edge(input logic [4:0] r, input logic rn);
    logic [4:0] e_sc, e_mc;
    e_sc = '0;
    e_mc = '0;
    if (!rn) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_first = '0;
      for (int i = 0; i < 5; i++) begin
        m_run[i] = 0;
        m_rc[i]  = 0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        logic smp;
        smp = m_s2[i];
        if (smp != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_db[i]  = smp;
            m_run[i] = 0;
            if (smp) begin
              e_sc[i]    = 1'b1;
              e_mc[i]    = 1'b1;
              m_rc[i]    = 0;
              m_first[i] = 1'b1;
            end
          end
        end else begin
          if (m_db[i] && m_run[i] == 0) begin
            m_rc[i]++;
            if (m_rc[i] == (m_first[i] ? RD : RP)) begin
              e_mc[i]    = 1'b1;
              m_rc[i]    = 0;
              m_first[i] = 1'b0;
            end
          end
          m_run[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = r[i];
      end
    end
    exp_q.push_back({m_db, e_sc, e_mc});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(raw, Reset_n);
    edge_cnt++;
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic chk(input string nm, input int act, input int expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [14:0] e, a;
      e = exp_q.pop_front();
      a = {Btn_db, Btn_SCEN, Btn_MCEN};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL outputs edge %0d: db/scen/mcen got %b/%b/%b expected %b/%b/%b",
                 edge_cnt, a[14:10], a[9:5], a[4:0], e[14:10], e[9:5], e[4:0]);
      end
      for (int i = 0; i < 5; i++) begin
        if (Btn_SCEN[i] === 1'b1) begin
          scen_edge[i] = edge_cnt;
          scen_cnt[i]++;
        end
        if (Btn_MCEN[i] === 1'b1) mcen_cnt[i]++;
        if (prev_db[i] === 1'b1 && Btn_db[i] === 1'b0) fall_edge[i] = edge_cnt;
      end
      prev_db = Btn_db;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, c0, c1, r;
    logic [6:0] bounce;
    for (int i = 0; i < 5; i++) begin
      scen_edge[i] = -1; fall_edge[i] = -1; scen_cnt[i] = 0; mcen_cnt[i] = 0;
      m_run[i] = 0; m_rc[i] = 0;
    end
    m_s1 = '0; m_s2 = '0; m_db = '0; m_first = '0;
    raw = '0;
    Reset_n = 1'b0;
    run(2);
    Reset_n = 1'b1;
    run(3);

    // Clean press on L
    raw[0] = 1'b1;
    e0 = edge_cnt + 1;
    run(12);
    chk("clean_press_scen_edge", scen_edge[0], e0 + 5);
    raw[0] = 1'b0;
    run(10);

    // Bounce rejection on U, then a genuine 6-cycle press
    c0 = scen_cnt[1];
    c1 = mcen_cnt[1];
    bounce = 7'b0111011;
    for (int j = 0; j < 7; j++) begin
      raw[1] = bounce[j];
      step();
    end
    raw[1] = 1'b0;
    run(8);
    chk("bounce_no_scen", scen_cnt[1] - c0, 0);
    chk("bounce_no_mcen", mcen_cnt[1] - c1, 0);
    raw[1] = 1'b1;
    run(6);
    raw[1] = 1'b0;
    run(12);
    chk("bounce_then_hold_scen", scen_cnt[1] - c0, 1);

    // Auto-repeat on R: pulses at P, P+10, P+15 ... P+35
    c0 = scen_cnt[3];
    c1 = mcen_cnt[3];
    raw[3] = 1'b1;
    run(6 + 36);
    chk("repeat_mcen_count", mcen_cnt[3] - c1, 7);
    chk("repeat_scen_count", scen_cnt[3] - c0, 1);
    raw[3] = 1'b0;
    run(10);

    // D: short dip inside HELD, then release latency
    c0 = scen_cnt[2];
    raw[2] = 1'b1;
    run(10);
    raw[2] = 1'b0;
    run(2);
    raw[2] = 1'b1;
    run(10);
    chk("dip_single_scen", scen_cnt[2] - c0, 1);
    chk("dip_db_fall", fall_edge[2], -1);
    raw[2] = 1'b0;
    e0 = edge_cnt + 1;
    run(10);
    chk("release_db_fall_edge", fall_edge[2], e0 + 5);

    // Simultaneous C and L
    raw[4] = 1'b1;
    raw[0] = 1'b1;
    e0 = edge_cnt + 1;
    run(10);
    chk("simul_scen_c", scen_edge[4], e0 + 5);
    chk("simul_scen_l", scen_edge[0], e0 + 5);
    raw = '0;
    run(10);

    // Reset during PRESS_QUAL, then during HELD with the button kept down
    raw[1] = 1'b1;
    run(3);
    Reset_n = 1'b0;
    step();
    Reset_n = 1'b1;
    raw[1] = 1'b0;
    run(8);
    raw[1] = 1'b1;
    run(10);
    Reset_n = 1'b0;
    step();
    r = edge_cnt;
    scen_edge[1] = -1;
    Reset_n = 1'b1;
    run(10);
    chk("reset_held_scen_edge", scen_edge[1], r + 6);
    raw = '0;
    run(10);

    // Randomized phases with varying toggle rates and occasional resets
    for (int ph = 0; ph < 12; ph++) begin
      int pr;
      pr = (ph % 3 == 0) ? 2 : ((ph % 3 == 1) ? 6 : 40);
      for (int c = 0; c < 200; c++) begin
        for (int i = 0; i < 5; i++)
          if ($urandom_range(pr - 1) == 0) raw[i] = ~raw[i];
        Reset_n = ($urandom_range(299) == 0) ? 1'b0 : 1'b1;
        step();
      end
    end
    Reset_n = 1'b1;
    raw = '0;
    run(20);

    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
